// File: rtl/uart_tx_path_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, default baud
// divisor for the 100 MHz system clock, and the line-level helper.
package uart_tx_path_pkg;

  localparam int CLK_FREQ_HZ      = 32'd100_000_000;
  localparam int UART_BAUD        = 32'd115_200;
  // 100 MHz / 115200 truncates to 868 clk cycles per bit
  localparam int DEFAULT_BAUD_DIV = CLK_FREQ_HZ / UART_BAUD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Serial line level for a given state: low for the start bit, the shift
  // register LSB during data bits, high (idle/stop) otherwise.
  function automatic logic line_level(input tx_state_t st, input logic [7:0] sh);
    logic lvl;
    case (st)
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = sh[0];
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_tx_path_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags. A write into a full
// FIFO is still accepted when a read happens on the same edge.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] r_data,
  output logic             full,
  output logic             empty
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_s;
  logic              full_r;
  logic              empty_r;
  logic              push_s;
  logic              pop_s;

  // Decide push/pop for this edge and the resulting occupancy
  always_comb begin
    pop_s   = rd & ~empty_r;
    push_s  = wr & (~full_r | pop_s);
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags; flags track the post-edge occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_s;
      full_r  <= (count_s == FULL_COUNT);
      empty_r <= (count_s == '0);
    end
  end

  // Storage array; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= w_data;
  end

  assign r_data = mem_r[rd_ptr_r];
  assign full   = full_r;
  assign empty  = empty_r;

endmodule

// File: rtl/uart_tx_path.sv
// UART transmit path: byte FIFO feeding an 8N1/8N2 serialiser, LSB first.
// Back-to-back frames are contiguous: the next byte is popped on the last
// cycle of the stop phase.
module uart_tx_path
  import uart_tx_path_pkg::*;
#(
  parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int FIFO_ADDR_W = 4,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       uart_tx,
  output logic       uart_tx_full,
  output logic       uart_tx_empty,
  output logic       busy,
  output logic       overflow
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t   state_r, state_s;
  logic [15:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic        tx_r, tx_s;
  logic        busy_r;
  logic        overflow_r;
  logic        pop_s;
  logic        bit_end_s;
  logic [7:0]  fifo_data_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  sync_fifo #(
    .WIDTH  (8),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_en),
    .rd     (pop_s),
    .w_data (wr_data),
    .r_data (fifo_data_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  assign bit_end_s = (baud_cnt_r == BIT_LAST);

  // Next-state logic: bit timing, shifting, and FIFO pops at frame start
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_s    = fifo_data_s;
          baud_cnt_s = 16'd0;
          state_s    = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          bit_idx_s  = 3'd0;
          state_s    = ST_DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          shift_s    = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          if (bit_idx_r == STOP_LAST) begin
            bit_idx_s = 3'd0;
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              shift_s = fifo_data_s;
              state_s = ST_START;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Line level follows the state being entered so it is registered in step
    tx_s = line_level(state_s, shift_s);
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != ST_IDLE);
      overflow_r <= overflow_r | (wr_en & fifo_full_s & ~pop_s);
    end
  end

  assign uart_tx       = tx_r;
  assign uart_tx_full  = fifo_full_s;
  assign uart_tx_empty = fifo_empty_s;
  assign busy          = busy_r;
  assign overflow      = overflow_r;

endmodule

// File: doc/uart_tx_path.md
Name: uart_tx_path

Overview:
Transmit path that feeds the board UART pin from byte writes issued by the core sequencer.
- Buffers bytes in a small synchronous FIFO.
- Serialises each byte as 8N1 (or 8N2), LSB first, at a fixed baud divisor.
- Drives the top-level uart_tx, uart_tx_full and uart_tx_empty signals directly.
- Single clock domain; the same clk/reset as the rest of the top.

Parameters:
- BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_ADDR_W, 4, log2 of FIFO depth; depth = 16 by default.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle.
- uart_tx  out  1  serial line; idles high.
- uart_tx_full  out  1  FIFO holds 2^FIFO_ADDR_W entries.
- uart_tx_empty  out  1  FIFO holds 0 entries (an in-flight frame is not counted).
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: uart_tx=1, uart_tx_empty=1, uart_tx_full=0, busy=0, overflow=0. FIFO pointers and count = 0, FSM = IDLE, baud counter = 0.
- Reset mid-frame: the line returns high immediately (asynchronous). The frame in progress and all queued bytes are discarded.
- FIFO write:
  - A byte is accepted when wr_en=1 and either the FIFO is not full, or a pop occurs in the same cycle.
  - wr_en=1 while full with no pop: byte dropped, overflow set. overflow clears only on reset.
- Flags: uart_tx_full and uart_tx_empty are registered and reflect the count after the current edge's push/pop. Pointers wrap modulo depth.
- Read-empty: a pop never occurs while empty. A write into an empty FIFO is visible to the FSM one cycle later.
- FSM states:
  - IDLE: uart_tx=1. If FIFO not empty: pop into the 8-bit shift register, clear the baud counter, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for BAUD_DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV*STOP_BITS cycles. On the last cycle:
    - FIFO not empty: pop and go directly to START (no idle gap).
    - Otherwise: go to IDLE.
- Latency:
  - Write at edge N into an empty FIFO with the FSM idle: empty deasserts after N.
  - Pop and START entry happen at edge N+1; uart_tx falls after edge N+1.
  - Frame length: (10 or 11)*BAUD_DIV cycles; back-to-back frames are contiguous.
- Timing: uart_tx is driven from a register (glitch-free). The baud counter is 16 bits, counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the default BAUD_DIV constant derived from the 100 MHz clock.
- Sub-module sync_fifo:
  - Parameterised width/depth.
  - Ports: wr, rd, w_data, r_data, full, empty.
  - Simultaneous read/write handled as above.
  - Reused later for the ethernet receive buffer.
- Top-level uart_tx_path: instantiates sync_fifo and contains the FSM, baud counter and shift register.

Test Plan:
1. BAUD_DIV=4; after reset, write 0xA5 once.
   - uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
   - busy falls 40 cycles after START entry; empty reasserts one cycle after the write.
2. BAUD_DIV=4; write 0x00 then 0xFF on consecutive cycles.
   - Two contiguous 40-cycle frames, no high gap between the first stop bit and the second start bit.
3. Hold the FSM in a frame and write 17 bytes 0x01..0x11.
   - uart_tx_full asserts after the 16th accepted write; byte 0x11 is dropped and overflow=1.
   - Bytes 0x01..0x10 are transmitted in order.
4. FIFO full and STOP ending (pop) with wr_en=1, wr_data=0x5A in the same cycle.
   - Write accepted, full stays 1, overflow unchanged; 0x5A appears as the last transmitted byte.
5. Assert reset for one half-cycle mid-DATA.
   - uart_tx=1 without waiting for a clock edge; empty=1, full=0, busy=0, overflow=0.
   - No further frames after release until a new write.
6. STOP_BITS=2, BAUD_DIV=4; write 0x3C.
   - Stop phase lasts 8 cycles; total frame 44 cycles.
